// File: rtl/ivred_pkg.sv
// Shared constants and FSM state encoding for the ivredcr vector reduction unit.
package ivred_pkg;

    localparam logic [2:0] OP_MAX = 3'b000;
    localparam logic [2:0] OP_MIN = 3'b001;
    localparam logic [2:0] OP_SUM = 3'b010;

    localparam logic SIZE_8  = 1'b0;
    localparam logic SIZE_16 = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_FOLD1 = 3'd2,
        S_FOLD2 = 3'd3,
        S_DONE  = 3'd4
    } ivred_state_e;

endpackage

// File: rtl/ivlane_comb.sv
// Lane-wise max/min/sum of two packed words, as 4x8-bit or 2x16-bit lanes.
module ivlane_comb
    import ivred_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic        size,
    output logic [31:0] y
);

    // op[3] selects signed compare; unknown op[2:0] codes fall through to max.
    function automatic logic [7:0] comb8(input logic [7:0] x, input logic [7:0] z,
                                         input logic [3:0] opc);
        logic x_gt;
        x_gt = opc[3] ? ($signed(x) > $signed(z)) : (x > z);
        case (opc[2:0])
            OP_MIN:  return x_gt ? z : x;
            OP_SUM:  return x + z;
            default: return x_gt ? x : z;
        endcase
    endfunction

    function automatic logic [15:0] comb16(input logic [15:0] x, input logic [15:0] z,
                                           input logic [3:0] opc);
        logic x_gt;
        x_gt = opc[3] ? ($signed(x) > $signed(z)) : (x > z);
        case (opc[2:0])
            OP_MIN:  return x_gt ? z : x;
            OP_SUM:  return x + z;
            default: return x_gt ? x : z;
        endcase
    endfunction

    always_comb begin
        y = '0;
        if (size == SIZE_16) begin
            for (int i = 0; i < 2; i++) begin
                y[16*i +: 16] = comb16(a[16*i +: 16], b[16*i +: 16], op);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                y[8*i +: 8] = comb8(a[8*i +: 8], b[8*i +: 8], op);
            end
        end
    end

endmodule

// File: rtl/ivredcr.sv
// Streaming vector reduction: accumulates packed-lane beats, folds lanes to one scalar.
// Handshakes: a beat moves when valid_i & ready_o, a result moves when valid_o & ready_i; valid holds until taken.
module ivredcr
    import ivred_pkg::*;
(
    input  logic         cpu_clock_i,
    input  logic         cpu_resetn_i,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [31:0]  data_i,
    input  logic         last_i,
    input  logic [3:0]   op_i,
    input  logic         size_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [31:0]  result_o,
    output ivred_state_e state_o
);

    ivred_state_e state_q, state_d;
    logic [31:0]  acc_q, acc_d;
    logic [3:0]   op_q, op_d;
    logic         size_q, size_d;
    logic         valid_q, valid_d;

    logic [31:0]  cmb_b;
    logic         cmb_size;
    logic [31:0]  cmb_y;
    logic         accept;

    // One combiner serves both beat accumulation and the lane folds.
    always_comb begin
        cmb_b    = data_i;
        cmb_size = size_q;
        case (state_q)
            S_FOLD1: cmb_b = acc_q >> 16;
            S_FOLD2: begin
                cmb_b    = acc_q >> 8;
                cmb_size = SIZE_8;
            end
            default: cmb_b = data_i;
        endcase
    end

    ivlane_comb u_comb (
        .a    (acc_q),
        .b    (cmb_b),
        .op   (op_q),
        .size (cmb_size),
        .y    (cmb_y)
    );

    assign ready_o = ((state_q == S_IDLE) || (state_q == S_ACC)) && !flush_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        size_d  = size_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = data_i;
                    op_d    = op_i;
                    size_d  = size_i;
                    state_d = last_i ? S_FOLD1 : S_ACC;
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d = cmb_y;
                    if (last_i) begin
                        state_d = S_FOLD1;
                    end
                end
            end
            S_FOLD1: begin
                acc_d = cmb_y;
                if (size_q == SIZE_16) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_FOLD2;
                end
            end
            S_FOLD2: begin
                acc_d   = cmb_y;
                state_d = S_DONE;
                valid_d = 1'b1;
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_resetn_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            size_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            size_q  <= size_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o  = valid_q;
    assign state_o  = state_q;
    assign result_o = (size_q == SIZE_16) ? {{16{op_q[3] & acc_q[15]}}, acc_q[15:0]}
                                          : {{24{op_q[3] & acc_q[7]}},  acc_q[7:0]};

endmodule

// File: tb/tb_ivredcr.sv
// Directed bench for ivredcr: reductions, latency, backpressure, flush and reset.
module tb_ivredcr;
    import ivred_pkg::*;

    logic         cpu_clock_i = 1'b0;
    logic         cpu_resetn_i;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [31:0]  data_i;
    logic         last_i;
    logic [3:0]   op_i;
    logic         size_i;
    logic         valid_o;
    logic         ready_i;
    logic [31:0]  result_o;
    ivred_state_e state_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    ivredcr dut (
        .cpu_clock_i  (cpu_clock_i),
        .cpu_resetn_i (cpu_resetn_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .last_i       (last_i),
        .op_i         (op_i),
        .size_i       (size_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .state_o      (state_o)
    );

    always #5 cpu_clock_i = ~cpu_clock_i;

    task automatic tick;
        @(posedge cpu_clock_i);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [3:0] op,
                             input logic sz);
        int n;
        n = 0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = last;
        op_i    = op;
        size_i  = sz;
        #1;
        while (ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout ready_o=%b expected 1", ready_o);
        end
        tick();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic wait_done(input int exp_edges, input string name);
        int n;
        logic [31:0] exp;
        n = 0;
        while (valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (valid_o !== 1'b1 || n != exp_edges) begin
            errors++;
            $display("FAIL %s_latency valid_o=%b edges=%0d expected edges=%0d", name, valid_o, n, exp_edges);
        end
        exp = exp_q.pop_front();
        checks++;
        if (result_o !== exp) begin
            errors++;
            $display("FAIL %s_result got=%h expected=%h", name, result_o, exp);
        end
    endtask

    task automatic consume(input string name);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || state_o !== S_IDLE || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_consume valid_o=%b state=%0d ready_o=%b expected 0,%0d,1",
                     name, valid_o, state_o, ready_o, S_IDLE);
        end
    endtask

    task automatic test_reset;
        cpu_resetn_i = 1'b0;
        flush_i = 1'b0; valid_i = 1'b0; data_i = '0; last_i = 1'b0;
        op_i = '0; size_i = 1'b0; ready_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (valid_o !== 1'b0 || result_o !== 32'h0 || state_o !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state valid_o=%b result=%h state=%0d expected 0,00000000,%0d",
                     valid_o, result_o, state_o, S_IDLE);
        end
        cpu_resetn_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready ready_o=%b expected 1", ready_o);
        end
    endtask

    task automatic test_max_min_8;
        exp_q.push_back(32'h0000007F);
        send_beat(32'h7F800102, 1'b0, 4'b1000, SIZE_8);
        send_beat(32'h0503FF10, 1'b1, 4'b1000, SIZE_8);
        wait_done(2, "smax8");
        consume("smax8");
        exp_q.push_back(32'h00000001);
        send_beat(32'h7F800102, 1'b0, 4'b0001, SIZE_8);
        send_beat(32'h0503FF10, 1'b1, 4'b0001, SIZE_8);
        wait_done(2, "umin8");
        consume("umin8");
    endtask

    task automatic test_min_16;
        exp_q.push_back(32'hFFFF8000);
        send_beat(32'h80007FFF, 1'b1, 4'b1001, SIZE_16);
        wait_done(1, "smin16");
        consume("smin16");
    endtask

    task automatic test_sum_8;
        exp_q.push_back(32'h00000001);
        send_beat(32'hFFFFFFFF, 1'b0, 4'b0010, SIZE_8);
        send_beat(32'h00000005, 1'b1, 4'b0010, SIZE_8);
        wait_done(2, "usum8");
        consume("usum8");
    endtask

    task automatic test_op_latch;
        // Later op/size changes must be ignored: 16-bit sum of (2+4)+(1+3).
        exp_q.push_back(32'h0000000A);
        send_beat(32'h00010002, 1'b0, 4'b0010, SIZE_16);
        send_beat(32'h00030004, 1'b1, 4'b1000, SIZE_8);
        wait_done(1, "op_latch");
        consume("op_latch");
    endtask

    task automatic test_reserved_op;
        exp_q.push_back(32'h000000F0);
        send_beat(32'h10F00230, 1'b1, 4'b0101, SIZE_8);
        wait_done(2, "reserved_op");
        consume("reserved_op");
    endtask

    task automatic test_backpressure;
        exp_q.push_back(32'h00000002);
        send_beat(32'h00020001, 1'b1, 4'b0000, SIZE_16);
        wait_done(1, "bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid_o !== 1'b1 || result_o !== 32'h00000002 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d valid_o=%b result=%h ready_o=%b expected 1,00000002,0",
                         i, valid_o, result_o, ready_o);
            end
        end
        valid_i = 1'b1; data_i = 32'hFFFFFFFF; last_i = 1'b1; op_i = 4'b0000; size_i = SIZE_16;
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL done_no_accept ready_o=%b expected 0", ready_o);
        end
        tick();
        ready_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        #1;
        checks++;
        if (state_o !== S_IDLE || valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release state=%0d valid_o=%b ready_o=%b expected %0d,0,1",
                     state_o, valid_o, ready_o, S_IDLE);
        end
    endtask

    task automatic test_flush;
        send_beat(32'hFFFFFFFF, 1'b0, 4'b0000, SIZE_16);
        send_beat(32'hFFFFFFFF, 1'b0, 4'b0000, SIZE_16);
        checks++;
        if (state_o !== S_ACC) begin
            errors++;
            $display("FAIL flush_pre state=%0d expected %0d", state_o, S_ACC);
        end
        flush_i = 1'b1; valid_i = 1'b1; data_i = 32'hFFFFFFFF; last_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready ready_o=%b expected 0", ready_o);
        end
        tick();
        flush_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        #1;
        checks++;
        if (state_o !== S_IDLE || valid_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL flush_state state=%0d valid_o=%b result=%h expected %0d,0,00000000",
                     state_o, valid_o, result_o, S_IDLE);
        end
        exp_q.push_back(32'h0000ABCD);
        send_beat(32'h1234ABCD, 1'b1, 4'b0000, SIZE_16);
        wait_done(1, "post_flush");
        consume("post_flush");
    endtask

    task automatic test_reset_fold2;
        send_beat(32'h11223344, 1'b1, 4'b0000, SIZE_8);
        checks++;
        if (state_o !== S_FOLD1) begin
            errors++;
            $display("FAIL rst_fold1 state=%0d expected %0d", state_o, S_FOLD1);
        end
        tick();
        checks++;
        if (state_o !== S_FOLD2) begin
            errors++;
            $display("FAIL rst_fold2 state=%0d expected %0d", state_o, S_FOLD2);
        end
        cpu_resetn_i = 1'b0;
        tick();
        checks++;
        if (valid_o !== 1'b0 || state_o !== S_IDLE || result_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_fold2_state valid_o=%b state=%0d result=%h expected 0,%0d,00000000",
                     valid_o, state_o, result_o, S_IDLE);
        end
        cpu_resetn_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_fold2_ready ready_o=%b expected 1", ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_max_min_8();
        test_min_16();
        test_sum_8();
        test_op_latch();
        test_reserved_op();
        test_backpressure();
        test_flush();
        test_reset_fold2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/ivredcr.md
IVREDCR -- requirements
Module: ivredcr

Interface
REQ-001 SHALL: cpu_clock_i  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL: cpu_resetn_i  in  1  synchronous, active-low reset.
REQ-003 SHALL: flush_i  in  1  synchronous abort of any in-flight reduction.
REQ-004 SHALL: valid_i  in  1  input beat valid.
REQ-005 SHALL: ready_o  out  1  input beat accepted when valid_i&ready_o.
REQ-006 SHALL: data_i  in  32  packed lanes, 4x8b or 2x16b.
REQ-007 SHALL: last_i  in  1  final beat of the vector.
REQ-008 SHALL: op_i  in  4  op[3]=signed; op[2:0]: 000 max, 001 min, 010 sum; other codes act as max.
REQ-009 SHALL: size_i  in  1  0=8-bit lanes, 1=16-bit lanes.
REQ-010 SHALL: valid_o  out  1  scalar result valid.
REQ-011 SHALL: ready_i  in  1  result consumed when valid_o&ready_i.
REQ-012 SHALL: result_o  out  32  reduced scalar, extended to 32 bits.

Function
REQ-013 SHALL: op_i and size_i are sampled on the first accepted beat and held for the whole transaction; later values are ignored.
REQ-014 SHALL: FSM states are IDLE, ACC, FOLD1, FOLD2, DONE.
REQ-015 SHALL: IDLE: the first accepted beat loads the accumulator with data_i; next state is FOLD1 if last_i, else ACC.
REQ-016 SHALL: ACC: each accepted beat combines lane-wise, acc=comb(acc,data_i); last_i moves to FOLD1.
REQ-017 SHALL: FOLD1: acc=comb(acc,acc>>16) at the latched size; next state is DONE if size=1, else FOLD2.
REQ-018 SHALL: FOLD2 (8-bit only): acc=comb(acc,acc>>8) at 8-bit lanes; next state is DONE.
REQ-019 SHALL: DONE: valid_o=1 and result_o is held stable until valid_o&ready_i, then IDLE.
REQ-020 SHALL: ready_o=1 only in IDLE/ACC with flush_i=0; ready_o=0 in FOLD1/FOLD2/DONE.
REQ-021 SHALL: latency: valid_o is high after the 1st (16-bit) or 2nd (8-bit) rising edge following the edge that accepted the last beat.
REQ-022 SHALL: max/min compare per lane, signed or unsigned per op[3].
REQ-023 SHALL: sum wraps modulo the lane width (2^8 or 2^16); there is no saturation.
REQ-024 SHALL: result_o is lane 0 of acc, sign-extended if op[3]=1, else zero-extended.
REQ-025 SHALL: flush_i=1 returns the FSM to IDLE next edge, clears valid_o, discards acc, and accepts no beat that cycle; flush_i overrides a simultaneous valid_i or ready_i.
REQ-026 SHALL: in DONE, ready_i=1 and a new valid_i in the same cycle: the beat is not accepted (ready_o=0); acceptance resumes the next cycle.
REQ-027 SHALL: there is no limit on beat count; the accumulator does not overflow beyond the lane wrap rule.

Reset
REQ-028 SHALL: cpu_resetn_i=0 forces IDLE, valid_o=0, acc=0, result_o=0, and latched op/size=0 at the next edge, from any state including FOLD1/FOLD2/DONE.
REQ-029 SHALL: ready_o=1 in the first cycle after reset deasserts.

Structure
REQ-030 SHALL: package ivred_pkg holds the op[2:0] code constants, the size encoding, and the FSM state enum.
REQ-031 SHALL: one combinational sub-module ivlane_comb(a,b,op,size)->y implements the lane-wise max/min/sum for 4x8 or 2x16 lanes.
REQ-032 SHALL: ivlane_comb is instantiated once in ivredcr and shared by ACC and FOLD via an operand mux.
REQ-033 SHALL: acc, state, latched op/size, and valid_o are the only registers; result_o is driven from acc.

Verification
REQ-034 SHALL: signed max, 8-bit, beats 0x7F800102, 0x0503FF10(last) -> result_o=0x0000007F; same beats with unsigned min -> 0x00000001.
REQ-035 SHALL: signed min, 16-bit, single beat 0x80007FFF with last -> result_o=0xFFFF8000; valid_o high after exactly 1 edge post-acceptance.
REQ-036 SHALL: unsigned sum, 8-bit, beats 0xFFFFFFFF, 0x00000005(last) -> result_o=0x00000001 (1025 mod 256).
REQ-037 SHALL: backpressure: ready_i=0 for 5 cycles in DONE -> valid_o, result_o stable, ready_o=0; on handshake, IDLE and ready_o=1 next cycle.
REQ-038 SHALL: flush_i after 2 ACC beats, then 16-bit unsigned max single beat 0x1234ABCD -> result_o=0x0000ABCD with no stale contribution.
REQ-039 SHALL: cpu_resetn_i=0 during FOLD2 -> next cycle valid_o=0, state IDLE, and ready_o=1 after deassertion.
